// File: rtl/if_fetch.sv
// if_fetch: instruction fetch stage with a direct-mapped, one-word-per-line
// instruction cache in front of a byte-wide memory port.
//
// A hit presents the cached word on the next cycle. A miss reads the word as
// four byte requests (little-endian) and then fills the cache line. Each
// returned byte arrives one cycle after its granted request.
//
// Parameters
//   IDX_W         cache index width (2^IDX_W lines)
// Ports
//   clk           system clock, all state changes on posedge
//   rst           synchronous active-high reset
//   pc            fetch address from the PC register
//   jump_flag     redirect: abandon the current fetch, clear if_valid
//   stall_in      downstream stall: hold the presented instruction
//   mem_grant     arbiter accepts this cycle's byte request
//   mem_din       byte returned one cycle after a granted request
//   mem_req       byte read request
//   mem_addr      byte address of the request
//   if_stall_req  fetch busy; the PC register must hold pc
//   if_valid      if_inst/if_pc hold a valid instruction
//   if_inst       fetched instruction
//   if_pc         word-aligned address of if_inst
module if_fetch #(
    parameter int unsigned IDX_W = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc,
    input  logic        jump_flag,
    input  logic        stall_in,
    input  logic        mem_grant,
    input  logic [7:0]  mem_din,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic        if_stall_req,
    output logic        if_valid,
    output logic [31:0] if_inst,
    output logic [31:0] if_pc
);

    localparam int unsigned LINES = 1 << IDX_W;
    localparam int unsigned TAG_W = 30 - IDX_W;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StWaitLast,
        StDone
    } state_t;

    state_t state;

    logic [31:0]       pc_lat;
    logic [1:0]        byte_k;     // next byte to request
    logic              cap_pend;   // a granted byte returns this cycle
    logic [1:0]        cap_idx;    // which byte it is
    logic [3:0][7:0]   word_buf;

    logic [31:0]       data_mem [LINES];
    logic [TAG_W-1:0]  tag_mem  [LINES];
    logic [LINES-1:0]  line_valid;

    logic [IDX_W-1:0]  rd_idx;
    logic [TAG_W-1:0]  rd_tag;
    logic [IDX_W-1:0]  wr_idx;
    logic [TAG_W-1:0]  wr_tag;
    logic              lookup_hit;
    logic              cache_we;
    logic [31:0]       pc_aligned;
    logic [31:0]       last_word;
    logic              unused_pc_lo;

    assign rd_idx       = pc[IDX_W+1:2];
    assign rd_tag       = pc[31:IDX_W+2];
    assign wr_idx       = if_pc[IDX_W+1:2];
    assign wr_tag       = if_pc[31:IDX_W+2];
    assign lookup_hit   = line_valid[rd_idx] && (tag_mem[rd_idx] == rd_tag);
    assign pc_aligned   = {pc[31:2], 2'b00};
    assign unused_pc_lo = ^pc[1:0];

    // Byte 3 may still be on mem_din when leaving WAIT_LAST; take it directly.
    assign last_word = cap_pend ? {mem_din, word_buf[2], word_buf[1], word_buf[0]} : word_buf;

    // The line is written from the presented word during DONE.
    assign cache_we = (state == StDone) && !rst && !jump_flag;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= StIdle;
            mem_req      <= 1'b0;
            mem_addr     <= '0;
            if_stall_req <= 1'b0;
            if_valid     <= 1'b0;
            if_inst      <= '0;
            if_pc        <= '0;
            pc_lat       <= '0;
            byte_k       <= '0;
            cap_pend     <= 1'b0;
            cap_idx      <= '0;
            word_buf     <= '0;
            line_valid   <= '0;
        end else if (jump_flag) begin
            // Clearing cap_pend drops any byte still in flight.
            state        <= StIdle;
            mem_req      <= 1'b0;
            if_stall_req <= 1'b0;
            if_valid     <= 1'b0;
            byte_k       <= '0;
            cap_pend     <= 1'b0;
        end else begin
            if (cap_pend) begin
                word_buf[cap_idx] <= mem_din;
            end
            cap_pend <= 1'b0;

            case (state)
                StIdle: begin
                    if (!stall_in) begin
                        if (lookup_hit) begin
                            if_valid <= 1'b1;
                            if_inst  <= data_mem[rd_idx];
                            if_pc    <= pc_aligned;
                        end else begin
                            state        <= StReq;
                            pc_lat       <= pc_aligned;
                            mem_req      <= 1'b1;
                            mem_addr     <= pc_aligned;
                            byte_k       <= '0;
                            if_stall_req <= 1'b1;
                            if_valid     <= 1'b0;
                        end
                    end
                end

                StReq: begin
                    if (mem_grant) begin
                        cap_pend <= 1'b1;
                        cap_idx  <= byte_k;
                        byte_k   <= byte_k + 2'd1;
                        if (byte_k == 2'd3) begin
                            state   <= StWaitLast;
                            mem_req <= 1'b0;
                        end else begin
                            mem_addr <= pc_lat + {30'd0, byte_k} + 32'd1;
                        end
                    end
                end

                StWaitLast: begin
                    // Byte 3 is banked by the capture above while stalled.
                    if (!stall_in) begin
                        state        <= StDone;
                        if_valid     <= 1'b1;
                        if_inst      <= last_word;
                        if_pc        <= pc_lat;
                        if_stall_req <= 1'b0;
                    end
                end

                StDone: begin
                    state              <= StIdle;
                    line_valid[wr_idx] <= 1'b1;
                end

                default: state <= StIdle;
            endcase
        end
    end

    // Data and tag arrays need no reset; line_valid guards them.
    always_ff @(posedge clk) begin
        if (cache_we) begin
            data_mem[wr_idx] <= if_inst;
            tag_mem[wr_idx]  <= wr_tag;
        end
    end

endmodule

// File: tb/tb_if_fetch.sv
module tb_if_fetch;

    localparam int unsigned IDX_W = 5;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc;
    logic        jump_flag;
    logic        stall_in;
    logic        mem_grant;
    logic [7:0]  mem_din;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        if_stall_req;
    logic        if_valid;
    logic [31:0] if_inst;
    logic [31:0] if_pc;

    if_fetch #(.IDX_W(IDX_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .pc           (pc),
        .jump_flag    (jump_flag),
        .stall_in     (stall_in),
        .mem_grant    (mem_grant),
        .mem_din      (mem_din),
        .mem_req      (mem_req),
        .mem_addr     (mem_addr),
        .if_stall_req (if_stall_req),
        .if_valid     (if_valid),
        .if_inst      (if_inst),
        .if_pc        (if_pc)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int req_cycles = 0;
    logic [31:0] grant_log[$];

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_t;
    exp_t exp_q[$];

    // Memory image: addresses 0..3 hold a NOP (0x00000013), others a hash.
    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        logic [7:0] lo;
        if (a < 32'd4) return (a == 32'd0) ? 8'h13 : 8'h00;
        lo = a[7:0];
        return (lo * 8'd7 + 8'h21) ^ a[15:8];
    endfunction

    function automatic logic [31:0] exp_word(input logic [31:0] p);
        logic [31:0] b;
        b = {p[31:2], 2'b00};
        return {mem_byte(b + 32'd3), mem_byte(b + 32'd2), mem_byte(b + 32'd1), mem_byte(b)};
    endfunction

    // Byte memory: answers each granted request one cycle later, junk otherwise.
    logic        mon_g;
    logic [31:0] mon_a;
    always @(posedge clk) begin
        mon_g = (mem_req === 1'b1) && (mem_grant === 1'b1);
        mon_a = mem_addr;
        if (mem_req === 1'b1) req_cycles++;
        if (mon_g) grant_log.push_back(mon_a);
        #1;
        mem_din = mon_g ? mem_byte(mon_a) : 8'hEE;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input int budget, output int cycles);
        cycles = -1;
        for (int c = 1; c <= budget; c++) begin
            tick();
            if (if_valid === 1'b1) begin
                cycles = c;
                break;
            end
        end
    endtask

    // Leave DONE (cache written), then clear if_valid with a one-cycle jump.
    task automatic flush();
        tick();
        jump_flag = 1'b1;
        tick();
        jump_flag = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; jump_flag = 1'b0; stall_in = 1'b0; mem_grant = 1'b1; pc = 32'h0;
        tick();
        tick();
        n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req: got %b required 0", mem_req); end
        n_checks++; if (mem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_mem_addr: got %h required 0", mem_addr); end
        n_checks++; if (if_stall_req !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b required 0", if_stall_req); end
        n_checks++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b required 0", if_valid); end
        n_checks++; if (if_inst !== 32'h0) begin n_fail++; $display("FAIL reset_inst: got %h required 0", if_inst); end
        n_checks++; if (if_pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h required 0", if_pc); end
        rst = 1'b0;
    endtask

    task automatic test_cold_miss();
        int lat;
        exp_t e;
        grant_log.delete();
        pc = 32'h0;
        exp_q.push_back({32'h0, exp_word(32'h0)});
        lat = -1;
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (if_valid === 1'b1) begin lat = c; break; end
            n_checks++;
            if (if_stall_req !== 1'b1) begin n_fail++; $display("FAIL cold_stall_c%0d: got %b required 1", c, if_stall_req); end
        end
        n_checks++; if (lat != 6) begin n_fail++; $display("FAIL cold_latency: got %0d required 6", lat); end
        e = exp_q.pop_front();
        n_checks++; if (if_inst !== e.inst) begin n_fail++; $display("FAIL cold_inst: got %h required %h", if_inst, e.inst); end
        n_checks++; if (if_pc !== e.pc) begin n_fail++; $display("FAIL cold_pc: got %h required %h", if_pc, e.pc); end
        n_checks++; if (if_stall_req !== 1'b0) begin n_fail++; $display("FAIL cold_stall_done: got %b required 0", if_stall_req); end
        n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL cold_req_done: got %b required 0", mem_req); end
        n_checks++; if (grant_log.size() != 4) begin n_fail++; $display("FAIL cold_nreq: got %0d required 4", grant_log.size()); end
        for (int i = 0; i < 4 && i < grant_log.size(); i++) begin
            n_checks++;
            if (grant_log[i] !== 32'(i)) begin n_fail++; $display("FAIL cold_addr%0d: got %h required %h", i, grant_log[i], 32'(i)); end
        end
        flush();
    endtask

    task automatic test_hit();
        int lat;
        int r0;
        exp_t e;
        logic [31:0] a;
        n_checks++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL hit_flushed: got %b required 0", if_valid); end
        r0 = req_cycles;
        pc = 32'h0;
        exp_q.push_back({32'h0, exp_word(32'h0)});
        wait_valid(4, lat);
        n_checks++; if (lat != 1) begin n_fail++; $display("FAIL hit_latency: got %0d required 1", lat); end
        e = exp_q.pop_front();
        n_checks++; if (if_inst !== e.inst) begin n_fail++; $display("FAIL hit_inst: got %h required %h", if_inst, e.inst); end
        n_checks++; if (req_cycles != r0) begin n_fail++; $display("FAIL hit_no_req: got %0d required %0d", req_cycles, r0); end
        // Fill line 1 so two lines can alternate.
        flush();
        pc = 32'h4;
        exp_q.push_back({32'h4, exp_word(32'h4)});
        wait_valid(12, lat);
        n_checks++; if (lat != 6) begin n_fail++; $display("FAIL fill4_latency: got %0d required 6", lat); end
        e = exp_q.pop_front();
        n_checks++; if (if_inst !== e.inst) begin n_fail++; $display("FAIL fill4_inst: got %h required %h", if_inst, e.inst); end
        flush();
        r0 = req_cycles;
        for (int i = 0; i < 6; i++) begin
            a = (i % 2 == 1) ? 32'h4 : 32'h0;
            pc = a;
            exp_q.push_back({a, exp_word(a)});
            tick();
            e = exp_q.pop_front();
            n_checks++;
            if (if_valid !== 1'b1 || if_inst !== e.inst || if_pc !== e.pc) begin
                n_fail++;
                $display("FAIL b2b_%0d: got v=%b %h@%h required v=1 %h@%h", i, if_valid, if_inst, if_pc, e.inst, e.pc);
            end
        end
        n_checks++; if (req_cycles != r0) begin n_fail++; $display("FAIL b2b_no_req: got %0d required %0d", req_cycles, r0); end
        flush();
    endtask

    task automatic test_grant_gaps();
        int lat;
        int base;
        int gap_left;
        exp_t e;
        base = grant_log.size();
        gap_left = 2;
        pc = 32'h20;
        exp_q.push_back({32'h20, exp_word(32'h20)});
        lat = -1;
        for (int c = 1; c <= 20; c++) begin
            if (mem_req === 1'b1 && grant_log.size() - base == 2 && gap_left > 0) begin
                mem_grant = 1'b0;
                gap_left--;
                n_checks++;
                if (mem_addr !== 32'h22) begin n_fail++; $display("FAIL gap_addr_hold: got %h required 00000022", mem_addr); end
            end else begin
                mem_grant = 1'b1;
            end
            tick();
            if (if_valid === 1'b1) begin lat = c; break; end
        end
        mem_grant = 1'b1;
        n_checks++; if (lat != 8) begin n_fail++; $display("FAIL gap_latency: got %0d required 8", lat); end
        e = exp_q.pop_front();
        n_checks++; if (if_inst !== e.inst) begin n_fail++; $display("FAIL gap_inst: got %h required %h", if_inst, e.inst); end
        flush();
    endtask

    task automatic test_jump();
        int lat;
        bit seen;
        exp_t e;
        pc = 32'h40;
        seen = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (mem_req === 1'b1 && mem_addr === 32'h41) begin seen = 1'b1; break; end
        end
        n_checks++; if (!seen) begin n_fail++; $display("FAIL jump_reach_byte1: got none required addr 00000041"); end
        jump_flag = 1'b1;
        tick();
        jump_flag = 1'b0;
        n_checks++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL jump_valid: got %b required 0", if_valid); end
        n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL jump_req: got %b required 0", mem_req); end
        n_checks++; if (if_stall_req !== 1'b0) begin n_fail++; $display("FAIL jump_stall: got %b required 0", if_stall_req); end
        // Same pc again: the abandoned line must not have been written.
        exp_q.push_back({32'h40, exp_word(32'h40)});
        wait_valid(12, lat);
        n_checks++; if (lat != 6) begin n_fail++; $display("FAIL jump_refetch_latency: got %0d required 6", lat); end
        e = exp_q.pop_front();
        n_checks++; if (if_inst !== e.inst) begin n_fail++; $display("FAIL jump_refetch_inst: got %h required %h", if_inst, e.inst); end
        flush();
    endtask

    task automatic test_alias();
        int lat;
        exp_t e;
        pc = 32'h80;
        exp_q.push_back({32'h80, exp_word(32'h80)});
        wait_valid(12, lat);
        n_checks++; if (lat != 6) begin n_fail++; $display("FAIL alias_latency: got %0d required 6", lat); end
        e = exp_q.pop_front();
        n_checks++; if (if_inst !== e.inst) begin n_fail++; $display("FAIL alias_inst: got %h required %h", if_inst, e.inst); end
        flush();
        pc = 32'h0;
        exp_q.push_back({32'h0, exp_word(32'h0)});
        wait_valid(12, lat);
        n_checks++; if (lat != 6) begin n_fail++; $display("FAIL alias_evicted_latency: got %0d required 6", lat); end
        e = exp_q.pop_front();
        n_checks++; if (if_inst !== e.inst) begin n_fail++; $display("FAIL alias_evicted_inst: got %h required %h", if_inst, e.inst); end
        flush();
    endtask

    task automatic test_stall();
        int lat;
        int base;
        exp_t e;
        pc = 32'h0;
        exp_q.push_back({32'h0, exp_word(32'h0)});
        wait_valid(4, lat);
        e = exp_q.pop_front();
        n_checks++; if (lat != 1 || if_inst !== e.inst) begin n_fail++; $display("FAIL stall_pre_hit: got lat %0d %h required lat 1 %h", lat, if_inst, e.inst); end
        stall_in = 1'b1;
        pc = 32'h4;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (if_valid !== 1'b1 || if_inst !== e.inst || if_pc !== e.pc) begin
                n_fail++;
                $display("FAIL stall_hold_%0d: got v=%b %h@%h required v=1 %h@%h", i, if_valid, if_inst, if_pc, e.inst, e.pc);
            end
        end
        stall_in = 1'b0;
        flush();
        // Stall raised mid-transaction: memory completes, presentation waits.
        base = grant_log.size();
        pc = 32'hC;
        exp_q.push_back({32'hC, exp_word(32'hC)});
        tick();
        tick();
        stall_in = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            n_checks++;
            if (if_valid !== 1'b0 || if_stall_req !== 1'b1) begin
                n_fail++;
                $display("FAIL stall_midfetch_%0d: got v=%b busy=%b required v=0 busy=1", i, if_valid, if_stall_req);
            end
        end
        n_checks++; if (grant_log.size() - base != 4) begin n_fail++; $display("FAIL stall_mem_done: got %0d required 4", grant_log.size() - base); end
        stall_in = 1'b0;
        tick();
        e = exp_q.pop_front();
        n_checks++;
        if (if_valid !== 1'b1 || if_inst !== e.inst || if_stall_req !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_release: got v=%b %h busy=%b required v=1 %h busy=0", if_valid, if_inst, if_stall_req, e.inst);
        end
        flush();
    endtask

    task automatic test_misaligned();
        int lat;
        int base;
        exp_t e;
        base = grant_log.size();
        pc = 32'h12;
        exp_q.push_back({32'h10, exp_word(32'h10)});
        wait_valid(12, lat);
        n_checks++; if (lat != 6) begin n_fail++; $display("FAIL misalign_latency: got %0d required 6", lat); end
        n_checks++;
        if (grant_log.size() <= base || grant_log[base] !== 32'h10) begin
            n_fail++;
            $display("FAIL misalign_byte0_addr: got %h required 00000010", (grant_log.size() > base) ? grant_log[base] : 32'hx);
        end
        e = exp_q.pop_front();
        n_checks++; if (if_inst !== e.inst || if_pc !== e.pc) begin n_fail++; $display("FAIL misalign_word: got %h@%h required %h@%h", if_inst, if_pc, e.inst, e.pc); end
        flush();
    endtask

    task automatic test_reset_mid();
        int lat;
        exp_t e;
        pc = 32'h24;
        tick();
        tick();
        n_checks++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL rstmid_in_req: got %b required 1", mem_req); end
        rst = 1'b1;
        jump_flag = 1'b1;
        tick();
        rst = 1'b0;
        jump_flag = 1'b0;
        n_checks++; if (mem_req !== 1'b0 || mem_addr !== 32'h0) begin n_fail++; $display("FAIL rstmid_mem: got %b %h required 0 00000000", mem_req, mem_addr); end
        n_checks++; if (if_stall_req !== 1'b0 || if_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_flags: got %b %b required 0 0", if_stall_req, if_valid); end
        n_checks++; if (if_inst !== 32'h0 || if_pc !== 32'h0) begin n_fail++; $display("FAIL rstmid_inst: got %h@%h required 0@0", if_inst, if_pc); end
        // Line 1 held pc 0x4 before reset; it must miss now.
        pc = 32'h4;
        exp_q.push_back({32'h4, exp_word(32'h4)});
        wait_valid(12, lat);
        n_checks++; if (lat != 6) begin n_fail++; $display("FAIL rstmid_miss_latency: got %0d required 6", lat); end
        e = exp_q.pop_front();
        n_checks++; if (if_inst !== e.inst) begin n_fail++; $display("FAIL rstmid_inst_refill: got %h required %h", if_inst, e.inst); end
        flush();
    endtask

    initial begin
        mem_din = 8'h00;
        test_reset();
        test_cold_miss();
        test_hit();
        test_grant_gaps();
        test_jump();
        test_alias();
        test_stall();
        test_misaligned();
        test_reset_mid();
        n_checks++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL scoreboard_drain: got %0d left required 0", exp_q.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/if_fetch.md
IF_FETCH -- requirements
Module: if_fetch

Interface
REQ-001 SHALL have parameter IDX_W, default 5, meaning instruction-cache index width (2^IDX_W direct-mapped one-word lines).
REQ-002 SHALL have port clk  input  1  system clock; all state changes on posedge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port pc  input  32  fetch address from the PC register.
REQ-005 SHALL have port jump_flag  input  1  redirect/flush; the current fetch is abandoned.
REQ-006 SHALL have port stall_in  input  1  downstream stall; hold the presented instruction.
REQ-007 SHALL have port mem_grant  input  1  memory arbiter accepts this cycle's byte request.
REQ-008 SHALL have port mem_din  input  8  byte returned one cycle after a granted request.
REQ-009 SHALL have port mem_req  output  1  byte read request.
REQ-010 SHALL have port mem_addr  output  32  byte address of the request.
REQ-011 SHALL have port if_stall_req  output  1  fetch busy; the PC register must hold pc (drives stall_signal[0]).
REQ-012 SHALL have port if_valid  output  1  if_inst/if_pc hold a valid instruction.
REQ-013 SHALL have port if_inst  output  32  fetched instruction, little-endian.
REQ-014 SHALL have port if_pc  output  32  address of if_inst.

Function
REQ-015 SHALL implement states IDLE, REQ (issue bytes 0..3), WAIT_LAST (capture byte 3), DONE.
REQ-016 In IDLE with stall_in low, SHALL look up cache index pc[IDX_W+1:2] and compare the tag pc[31:IDX_W+2] with the valid bit.
REQ-017 On a hit, SHALL present if_inst/if_pc with if_valid high on the next cycle, with no memory request; back-to-back hits SHALL sustain one instruction per cycle.
REQ-018 On a miss, SHALL enter REQ and assert if_stall_req from that cycle until the DONE cycle inclusive of the transition.
REQ-019 In REQ, SHALL drive mem_req=1 and mem_addr=pc_latched+k for byte k; k SHALL advance only on a cycle with mem_grant=1.
REQ-020 SHALL capture mem_din one cycle after each granted request into byte k (bits 8k+7:8k).
REQ-021 After byte 3 is granted, SHALL go to WAIT_LAST, capture byte 3, then go to DONE.
REQ-022 In DONE, SHALL write the word, tag and valid bit into the cache, present if_valid=1 with the word, deassert if_stall_req, and return to IDLE.
REQ-023 Miss latency with mem_grant held high SHALL be 6 cycles from the miss cycle to if_valid.
REQ-024 Byte 0 of a fetch SHALL carry latched pc bits [1:0]=00; nonzero pc[1:0] SHALL be forced to 00.
REQ-025 mem_req SHALL be low in IDLE, WAIT_LAST and DONE.
REQ-026 jump_flag=1 in any state SHALL clear if_valid, drop mem_req, discard partial bytes, skip the cache write, and go to IDLE on the next cycle.
REQ-027 A byte returning after a jump_flag SHALL be ignored.
REQ-028 jump_flag SHALL take priority over stall_in and DONE.
REQ-029 stall_in=1 SHALL hold if_inst, if_pc and if_valid unchanged.
REQ-030 A stall_in=1 arriving during REQ/WAIT_LAST SHALL let the memory transaction finish, and DONE SHALL wait until stall_in=0.
REQ-031 Cache writes SHALL overwrite the indexed line unconditionally; there SHALL be no invalidation other than reset.

Reset
REQ-032 rst=1 SHALL force state IDLE, mem_req=0, mem_addr=0, if_stall_req=0, if_valid=0, if_inst=0, if_pc=0, clear all cache valid bits, and take priority over jump_flag.
REQ-033 rst asserted mid-fetch SHALL abandon the fetch with no cache write.

Verification
REQ-034 Cold miss: pc=0x00000000, grant=1, bytes 13,00,00,00 -> mem_addr 0,1,2,3; if_inst=0x00000013 and if_pc=0 on cycle 6; if_stall_req high during cycles 1-5.
REQ-035 Hit after fill: refetch pc=0 -> if_valid next cycle, if_inst=0x00000013, mem_req never asserted.
REQ-036 Grant gaps: mem_grant low 2 cycles before byte 2 -> mem_addr holds pc+2, latency 8, correct word.
REQ-037 Jump mid-fetch: jump_flag at byte 1 -> if_valid=0, no cache write; later fetch of the same pc misses again.
REQ-038 Alias: fetch 0x00000000 then 0x00000080 (IDX_W=5) -> second miss evicts the first; refetching 0x0 misses.
REQ-039 Reset mid-fetch: rst during REQ -> all outputs 0 next cycle, prior hits now miss.
